// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding an 8N1 serial transmitter with a registered line output.
// A write into a full FIFO is kept only when the transmitter pops a byte on the same edge.
module uart_tx_buf #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_rdy,
  output logic       o_serial_data,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       drop_err
);

  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (low) for one bit period
  // DATA  | data bits shift[idx], LSB first
  // STOP  | stop bit (high); last cycle pops the next byte if one is queued

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(DIV - 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BCW-1:0]  baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            drop_q, drop_d;
  logic            serial_q, serial_d;
  logic [7:0]      mem [DEPTH];

  logic            baud_tc;
  logic            non_empty;
  logic            pop;
  logic            push;

  assign baud_tc   = (baud_q == '0);
  assign non_empty = (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      serial_q <= serial_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (non_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = BAUD_LAST;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tc) begin
          baud_d  = BAUD_LAST;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BCW'(1);
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = BAUD_LAST;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BCW'(1);
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          if (non_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            baud_d  = BAUD_LAST;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop on the same edge frees the slot a full-FIFO write needs.
  always_comb begin
    push     = tx_data_rdy && ((count_q != FULL_CNT) || pop);
    drop_d   = drop_q || (tx_data_rdy && !push);
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = shift_d[idx_d];
      default: serial_d = 1'b1;
    endcase
  end

  assign o_serial_data = serial_q;
  assign tx_busy       = (state_q != S_IDLE) || non_empty;
  assign fifo_full     = (count_q == FULL_CNT);
  assign drop_err      = drop_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: directed scenarios plus random traffic, every cycle compared
// against a queue-and-timestamp model of the serial line.
module tb_uart_tx_buf;

  localparam int DIV_A = 104;
  localparam int DIV_B = 10;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_s = 1'b1;
  logic       rdy_s = 1'b0;
  logic [7:0] dat_s = 8'h00;
  int         sel = 0;

  logic line_a, busy_a, full_a, drop_a;
  logic line_b, busy_b, full_b, drop_b;
  logic line_o, busy_o, full_o, drop_o;

  always #5 clk = ~clk;

  uart_tx_buf u_dut_a (
    .clk           (clk),
    .rst           (rst_s),
    .tx_data       (dat_s),
    .tx_data_rdy   (rdy_s && (sel == 0)),
    .o_serial_data (line_a),
    .tx_busy       (busy_a),
    .fifo_full     (full_a),
    .drop_err      (drop_a)
  );

  uart_tx_buf #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(DEPTH)) u_dut_b (
    .clk           (clk),
    .rst           (rst_s),
    .tx_data       (dat_s),
    .tx_data_rdy   (rdy_s && (sel == 1)),
    .o_serial_data (line_b),
    .tx_busy       (busy_b),
    .fifo_full     (full_b),
    .drop_err      (drop_b)
  );

  assign line_o = (sel == 0) ? line_a : line_b;
  assign busy_o = (sel == 0) ? busy_a : busy_b;
  assign full_o = (sel == 0) ? full_a : full_b;
  assign drop_o = (sel == 0) ? drop_a : drop_b;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a frame popped at edge s occupies edges s .. s+10*DIV-1; bit p = (n-s)/DIV.
  logic [7:0] mq[$];
  bit         m_fr = 1'b0;
  int         m_start = 0;
  int         m_n = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_drop = 1'b0;
  int         mdiv = DIV_A;

  task automatic model_edge();
    int  pre;
    bit  popped;
    m_n++;
    if (rst_s) begin
      mq.delete();
      m_fr   = 1'b0;
      m_drop = 1'b0;
      return;
    end
    pre    = mq.size();
    popped = 1'b0;
    if (m_fr) begin
      if (m_n - m_start == 10 * mdiv) begin
        if (mq.size() > 0) begin
          m_cur   = mq.pop_front();
          m_start = m_n;
          popped  = 1'b1;
        end else begin
          m_fr = 1'b0;
        end
      end
    end else if (mq.size() > 0) begin
      m_cur   = mq.pop_front();
      m_start = m_n;
      m_fr    = 1'b1;
      popped  = 1'b1;
    end
    if (rdy_s) begin
      if (pre < DEPTH || popped) mq.push_back(dat_s);
      else m_drop = 1'b1;
    end
  endtask

  function automatic logic m_line();
    int p;
    if (!m_fr) return 1'b1;
    p = (m_n - m_start) / mdiv;
    if (p == 0) return 1'b0;
    if (p <= 8) return m_cur[p-1];
    return 1'b1;
  endfunction

  task automatic step();
    logic [2:0] exp_flags;
    @(posedge clk);
    model_edge();
    #1;
    exp_flags = {(m_fr || mq.size() != 0), (mq.size() == DEPTH), m_drop};
    chk("line", line_o, m_line());
    chk("flags", {busy_o, full_o, drop_o}, exp_flags);
  endtask

  task automatic do_reset();
    rst_s = 1'b1;
    rdy_s = 1'b0;
    step();
    rst_s = 1'b0;
  endtask

  task automatic write(input logic [7:0] b);
    dat_s = b;
    rdy_s = 1'b1;
    step();
    rdy_s = 1'b0;
  endtask

  // Called right after a write into an idle, empty block: samples each bit centre.
  task automatic frame_check(input logic [7:0] b);
    logic [9:0] fr;
    int off;
    fr  = {1'b1, b, 1'b0};
    dat_s = 8'($urandom);
    step();
    chk("first_low", line_o, 1'b0);
    off = 0;
    for (int i = 0; i < 10; i++) begin
      while (off < i * mdiv + mdiv / 2) begin
        step();
        off++;
      end
      chk("bit_centre", line_o, fr[i]);
    end
    while (off < 10 * mdiv - 1) begin
      step();
      off++;
    end
    chk("busy_last_stop", busy_o, 1'b1);
    step();
    chk("busy_after_stop", busy_o, 1'b0);
  endtask

  initial begin
    int g;
    int lows;
    int highs;

    // Reset state on the default-parameter block
    sel  = 0;
    mdiv = DIV_A;
    do_reset();
    do_reset();
    chk("rst_line", line_o, 1'b1);
    chk("rst_flags", {busy_o, full_o, drop_o}, 3'b000);

    // rdy together with rst is ignored
    rst_s = 1'b1; rdy_s = 1'b1; dat_s = 8'hC3;
    step();
    rst_s = 1'b0; rdy_s = 1'b0;
    step();
    chk("rst_rdy_ignored", busy_o, 1'b0);

    // Single byte 0x1B
    write(8'h1B);
    frame_check(8'h1B);
    repeat (20) step();

    // Burst overflow 0x30..0x39
    for (int i = 0; i < 10; i++) begin
      dat_s = 8'h30 + 8'(i);
      rdy_s = 1'b1;
      step();
      if (i == 8) chk("full_after_9th", full_o, 1'b1);
    end
    rdy_s = 1'b0;
    chk("drop_0x39", drop_o, 1'b1);
    g = 0;
    while (busy_o && g < 12000) begin
      step();
      g++;
    end
    chk("burst_drained", busy_o, 1'b0);
    chk("drop_sticky", drop_o, 1'b1);
    do_reset();
    chk("drop_cleared", drop_o, 1'b0);

    // Full FIFO plus a write on the STOP-final edge
    write(8'h11);
    for (int i = 0; i < 8; i++) write(8'($urandom));
    chk("filled_full", full_o, 1'b1);
    g = 0;
    while (!(m_fr && (m_n + 1 - m_start == 10 * mdiv)) && g < 2000) begin
      step();
      g++;
    end
    chk("stop_edge_reached", (g < 2000), 1'b1);
    write(8'hEE);
    chk("full_pop_full", full_o, 1'b1);
    chk("full_pop_nodrop", drop_o, 1'b0);
    chk("full_pop_restart", line_o, 1'b0);
    do_reset();

    // Reset in the middle of data bit 3 of 0xA5 with three bytes queued
    write(8'hA5);
    write(8'h01);
    write(8'h02);
    write(8'h03);
    g = 0;
    while (!(m_fr && (m_n + 1 - m_start == 4 * mdiv + 50)) && g < 2000) begin
      step();
      g++;
    end
    chk("bit3_reached", (g < 2000), 1'b1);
    do_reset();
    chk("abort_line", line_o, 1'b1);
    chk("abort_busy", busy_o, 1'b0);
    repeat (1500) step();
    chk("no_more_frames", busy_o, 1'b0);
    write(8'h55);
    frame_check(8'h55);

    // DIV=10 block: 0x00 gives 90 low cycles then a 10-cycle stop bit
    sel  = 1;
    mdiv = DIV_B;
    do_reset();
    write(8'h00);
    lows = 0;
    step();
    while (line_o == 1'b0 && lows < 200) begin
      lows++;
      step();
    end
    chk("low_run", lows, 90);
    highs = 0;
    while (busy_o && line_o && highs < 50) begin
      highs++;
      step();
    end
    chk("stop_run", highs, 10);

    // Random traffic alternating bursty and sparse phases
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (((c / 500) % 2) == 0) rdy_s = ($urandom_range(0, 99) < 50);
      else                      rdy_s = ($urandom_range(0, 99) < 4);
      dat_s = 8'($urandom);
      rst_s = ($urandom_range(0, 699) == 0);
      step();
    end
    rst_s = 1'b0;
    rdy_s = 1'b0;
    g = 0;
    while (busy_o && g < 2000) begin
      step();
      g++;
    end
    chk("random_drained", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
